circuito_2b_reg: RTL and testbench
==================================

Name: circuito_2b_reg

Overview:
- Registered 4-input Boolean function block for Unidade 1, questão 2, circuit 2B.
- Samples four single-bit inputs a, b, c, d and drives one registered output x.
- The function is set by a 16-entry truth-table parameter; the default implements x = (a AND b) OR (c AND NOT d).
- Used as a leaf cell wherever a clocked version of the circuit-2B function is needed.

Parameters:
- TRUTH_TABLE, 16'hF444: bit i is the value of x for input index i = {a,b,c,d}, with a as MSB and d as LSB.
- RESET_VALUE, 1'b0: value x takes while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- a  input  1  function input, index bit 3 (MSB).
- b  input  1  function input, index bit 2.
- c  input  1  function input, index bit 1.
- d  input  1  function input, index bit 0 (LSB).
- x  output  1  registered function result.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - rst high forces x = RESET_VALUE immediately, with no clock edge required.
  - x holds RESET_VALUE for as long as rst is high, regardless of a..d.
- Operation:
  - On each rising clk with rst low: x <= TRUTH_TABLE[{a,b,c,d}].
  - Latency is exactly 1 cycle from the input sample to x.
  - No enable and no handshake: every cycle produces a new result.
- Default truth table (index: x):
  - 0000:0, 0001:0, 0010:1, 0011:0
  - 0100:0, 0101:0, 0110:1, 0111:0
  - 1000:0, 1001:0, 1010:1, 1011:0
  - 1100:1, 1101:1, 1110:1, 1111:1
- Reset release:
  - Deassertion of rst is synchronised to the clock domain by the integrator.
  - The first rising edge after release loads the function of the current inputs.
- Reset mid-operation: asserting rst at any time overrides any pending update; x goes to RESET_VALUE at once.
- Input changes between edges have no effect on x. x is glitch-free because it is a flop output.
- Unknown inputs: X/Z on a..d produces X on x; the block does no X-squashing.
- State is a single flop. No other storage, no state machine.

Test Plan:
- Reset check:
  - Stimulus: rst=1 with a,b,c,d = 1,1,1,1, then toggle clk.
  - Required: x stays 0, and x drops to 0 asynchronously when rst is asserted while x=1.
- Exhaustive sweep:
  - Stimulus: rst=0; apply all 16 combinations {a,b,c,d} = 0000..1111, one per cycle.
  - Required: x one cycle later equals TRUTH_TABLE bit, i.e. 1 only for indices 2, 6, 10, 12, 13, 14, 15.
- Latency check:
  - Stimulus: change inputs 0000→0010 just after a rising edge.
  - Required: x stays 0 until the next rising edge, then becomes 1.
- Mid-run reset:
  - Stimulus: with inputs 1100 (x=1), pulse rst high for less than one clock period, between edges.
  - Required: x=0 immediately; at the first edge after release, x=1 again.
- Back-to-back toggles:
  - Stimulus: alternate inputs 1110 and 0001 every cycle for 8 cycles.
  - Required: x alternates 1,0,1,0,… delayed by one cycle.
- Parameter override:
  - Stimulus: instantiate with TRUTH_TABLE=16'h8000 and RESET_VALUE=1; then assert rst; then apply 1111 and 1110.
  - Required: x=1 while rst is high; after release, x=1 for 1111 and x=0 for 1110.

Source files
------------

// File: rtl/circuito_2b_reg.sv
// Registered 4-input Boolean function (circuit 2B): x is a flopped truth-table
// lookup of {a,b,c,d}, default x = (a & b) | (c & ~d).
module circuito_2b_reg #(
  parameter logic [15:0] TRUTH_TABLE = 16'hF444,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic x
);

  localparam int unsigned IDX_W = 4;

  logic [IDX_W-1:0] idx_c;
  logic             x_d;
  logic             x_q;

  // Table index: a is the MSB, d the LSB; X/Z on any input propagates to x.
  assign idx_c = {a, b, c, d};

  always_comb begin
    x_d = TRUTH_TABLE[idx_c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= RESET_VALUE;
    end else begin
      x_q <= x_d;
    end
  end

  assign x = x_q;

endmodule

// File: tb/tb_circuito_2b_reg.sv
// Directed bench for circuito_2b_reg: default instance plus a parameter-override instance.
module tb_circuito_2b_reg;

  logic clk;
  logic rst;
  logic rst_p;
  logic a, b, c, d;
  logic x;
  logic x_p;

  int n_checks;
  int n_fail;

  circuito_2b_reg u_dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .x   (x)
  );

  circuito_2b_reg #(
    .TRUTH_TABLE (16'h8000),
    .RESET_VALUE (1'b1)
  ) u_ovr (
    .clk (clk),
    .rst (rst_p),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .x   (x_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(4'b1111);
    #1;
    n_checks++;
    if (x !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: x=%b expected 0", x);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (x !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: x=%b expected 0", k, x);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (x !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_load: x=%b expected 1", x);
    end
    // Assert rst between edges while x=1: must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (x !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_clear: x=%b expected 0", x);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic exp;
    for (int i = 0; i < 16; i++) begin
      set_in(4'(i));
      @(posedge clk); #1;
      exp = (i == 2) || (i == 6) || (i == 10) || (i >= 12);
      n_checks++;
      if (x !== exp) begin
        n_fail++;
        $display("FAIL sweep[%0d]: x=%b expected %b", i, x, exp);
      end
    end
  endtask

  task automatic test_latency();
    set_in(4'b0000);
    @(posedge clk); #1;
    n_checks++;
    if (x !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_base: x=%b expected 0", x);
    end
    set_in(4'b0010);
    #3;
    n_checks++;
    if (x !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_before_edge: x=%b expected 0", x);
    end
    @(posedge clk); #1;
    n_checks++;
    if (x !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_after_edge: x=%b expected 1", x);
    end
  endtask

  task automatic test_midrun_reset();
    set_in(4'b1100);
    @(posedge clk); #1;
    n_checks++;
    if (x !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre: x=%b expected 1", x);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (x !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_async: x=%b expected 0", x);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (x !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_released_no_edge: x=%b expected 0", x);
    end
    @(posedge clk); #1;
    n_checks++;
    if (x !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reload: x=%b expected 1", x);
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    for (int k = 0; k < 8; k++) begin
      set_in((k % 2 == 0) ? 4'b1110 : 4'b0001);
      exp = (k % 2 == 0);
      @(posedge clk); #1;
      n_checks++;
      if (x !== exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: x=%b expected %b", k, x, exp);
      end
    end
  endtask

  task automatic test_param_override();
    set_in(4'b0000);
    rst_p = 1'b1;
    #1;
    n_checks++;
    if (x_p !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_reset: x_p=%b expected 1", x_p);
    end
    @(posedge clk); #1;
    n_checks++;
    if (x_p !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_reset_hold: x_p=%b expected 1", x_p);
    end
    rst_p = 1'b0;
    set_in(4'b1111);
    @(posedge clk); #1;
    n_checks++;
    if (x_p !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_1111: x_p=%b expected 1", x_p);
    end
    set_in(4'b1110);
    @(posedge clk); #1;
    n_checks++;
    if (x_p !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_1110: x_p=%b expected 0", x_p);
    end
    #2 rst_p = 1'b1;
    #1;
    n_checks++;
    if (x_p !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_async_set: x_p=%b expected 1", x_p);
    end
    @(posedge clk); #1;
    rst_p = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rst_p    = 1'b1;
    set_in(4'b0000);
    test_reset();
    test_sweep();
    test_latency();
    test_midrun_reset();
    test_back_to_back();
    test_param_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
